// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the branch compare stage:
//   - funct3 codes (F3_BEQ .. F3_BGEU)
//   - pipeline state encodings (ST_EMPTY, ST_FULL, ST_SKID)
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ST_SKID is only reachable when the skid buffer is built in.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

endpackage

// File: rtl/cmp_core.sv
// -----------------------------------------------------------------------------
// cmp_core
// Combinational signed/unsigned less-than and equality comparator.
// Ports:
//   a, b   in   N  operands
//   lt_s   out  1  signed (two's complement) a < b
//   lt_u   out  1  unsigned a < b
//   eq     out  1  a == b
// -----------------------------------------------------------------------------
module cmp_core #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt_s,
    output logic         lt_u,
    output logic         eq
);

    logic sign_diff;
    logic lt_low;

    // One N-1 bit magnitude compare serves both flavours; only the sign
    // bits decide differently when they disagree.
    assign sign_diff = a[N-1] ^ b[N-1];
    assign lt_low    = a[N-2:0] < b[N-2:0];

    // Signs differ: the negative operand (MSB set) is the smaller one.
    assign lt_s = sign_diff ? a[N-1] : lt_low;
    // Unsigned: MSBs differ means the operand with MSB clear is smaller.
    assign lt_u = sign_diff ? b[N-1] : lt_low;
    assign eq   = (a == b);

endmodule

// File: rtl/branch_cmp_stage.sv
// -----------------------------------------------------------------------------
// branch_cmp_stage
// Registered compare stage between register read and branch/writeback.
// Evaluates the funct3 condition on two operands and registers a branch-taken
// flag plus an SLT/SLTU result word, with valid/ready on both sides and
// one-cycle latency.
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_i        in   1      asynchronous active-high reset
//   in_valid_i   in   1      operand beat valid
//   in_ready_o   out  1      stage can accept a beat
//   a_i, b_i     in   N      operands rs1 / rs2
//   funct3_i     in   3      compare code (see cmp_pkg)
//   tag_i        in   TAG_W  sideband tag, carried unmodified
//   out_valid_o  out  1      result valid
//   out_ready_i  in   1      consumer accepts result
//   taken_o      out  1      branch condition true (0 for SLT/SLTU)
//   result_o     out  N      {0.., lt} for SLT/SLTU, 0 for branch codes
//   tag_o        out  TAG_W  tag of the presented beat
// Configuration:
//   BRANCH_CMP_SKID_EN  registered in_ready_o plus a one-entry skid buffer
//                       (third state ST_SKID). Undefined: two-state stage
//                       with in_ready_o = !out_valid_o || out_ready_i.
// -----------------------------------------------------------------------------
module branch_cmp_stage
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    input  logic [2:0]       funct3_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             taken_o,
    output logic [N-1:0]     result_o,
    output logic [TAG_W-1:0] tag_o
);

    typedef struct packed {
        logic             taken;
        logic [N-1:0]     result;
        logic [TAG_W-1:0] tag;
    } beat_t;

    state_t state_q, state_d;
    beat_t  out_q;
    beat_t  new_beat;
    logic   lt_s, lt_u, eq;
    logic   in_xfer, out_xfer;

    cmp_core #(.N(N)) u_cmp_core (
        .a    (a_i),
        .b    (b_i),
        .lt_s (lt_s),
        .lt_u (lt_u),
        .eq   (eq)
    );

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    // funct3 decode into the beat that would be registered this cycle.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        new_beat        = '0;
        new_beat.tag    = tag_i;
        case (funct3_i)
            F3_BEQ:  new_beat.taken  = eq;
            F3_BNE:  new_beat.taken  = !eq;
            F3_SLT:  new_beat.result = {{(N-1){1'b0}}, lt_s};
            F3_SLTU: new_beat.result = {{(N-1){1'b0}}, lt_u};
            F3_BLT:  new_beat.taken  = lt_s;
            F3_BGE:  new_beat.taken  = !lt_s;
            F3_BLTU: new_beat.taken  = lt_u;
            default: new_beat.taken  = !lt_u;   // F3_BGEU
        endcase
    end

`ifdef BRANCH_CMP_SKID_EN

    beat_t skid_q;
    logic  in_ready_q;

    // State register; in_ready_q follows the next state so that the ready
    // output is a plain flop with no path from out_ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_FULL;
            ST_FULL: begin
                if (in_xfer && !out_ready_i)      state_d = ST_SKID;
                else if (out_xfer && !in_xfer)    state_d = ST_EMPTY;
            end
            ST_SKID:  if (out_xfer) state_d = ST_FULL;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Output and skid registers. A new beat goes straight to the output
    // unless the output is occupied and stalled, in which case it lands in
    // the skid entry and is promoted once the output drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            // NOTE: the skid entry is cleared on reset so a stale beat can
            // never be promoted after an in-flight transfer is dropped.
            skid_q <= '0;
        end else begin
            if (in_xfer && (state_q != ST_FULL || out_ready_i))
                out_q <= new_beat;
            else if (state_q == ST_SKID && out_xfer)
                out_q <= skid_q;

            if (in_xfer && state_q == ST_FULL && !out_ready_i)
                skid_q <= new_beat;
        end
    end

    always_comb begin
        out_valid_o = (state_q != ST_EMPTY);
        in_ready_o  = in_ready_q;
        taken_o     = out_q.taken;
        result_o    = out_q.result;
        tag_o       = out_q.tag;
    end

`else

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_FULL;
            ST_FULL:  if (out_xfer && !in_xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        out_q <= '0;
        else if (in_xfer) out_q <= new_beat;
    end

    always_comb begin
        out_valid_o = (state_q != ST_EMPTY);
        // Accept when empty or when the current result leaves this edge.
        in_ready_o  = !out_valid_o || out_ready_i;
        taken_o     = out_q.taken;
        result_o    = out_q.result;
        tag_o       = out_q.tag;
    end

`endif

endmodule

// File: tb/tb_branch_cmp_stage.sv
module tb_branch_cmp_stage;
    import cmp_pkg::*;

    localparam int N     = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic             taken;
        logic [N-1:0]     result;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct {
        logic [2:0]   f3;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         taken;
        logic [N-1:0] result;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [N-1:0]     a_i, b_i;
    logic [2:0]       funct3_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             taken_o;
    logic [N-1:0]     result_o;
    logic [TAG_W-1:0] tag_o;

    int    checks   = 0;
    int    failures = 0;
    int    popped   = 0;
    int    cyc      = 0;
    beat_t sb[$];

    branch_cmp_stage #(.N(N), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .funct3_i    (funct3_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .taken_o     (taken_o),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written from the arithmetic definition, not the
    // sign-split structure used in the design.
    function automatic beat_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [2:0] f3, input logic [TAG_W-1:0] tag);
        beat_t r;
        logic  lts, ltu, e;
        lts = $signed(a) < $signed(b);
        ltu = a < b;
        e   = (a == b);
        r   = '0;
        r.tag = tag;
        case (f3)
            F3_BEQ:  r.taken  = e;
            F3_BNE:  r.taken  = !e;
            F3_SLT:  r.result = lts ? 1 : 0;
            F3_SLTU: r.result = ltu ? 1 : 0;
            F3_BLT:  r.taken  = lts;
            F3_BGE:  r.taken  = !lts;
            F3_BLTU: r.taken  = ltu;
            default: r.taken  = !ltu;
        endcase
        return r;
    endfunction

    // Drive one beat, wait (bounded) for acceptance, then push its expectation.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] f3,
                        input logic [TAG_W-1:0] tag, input beat_t exp);
        bit ok = 0;
        a_i = a; b_i = b; funct3_i = f3; tag_i = tag; in_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
            sb.push_back(exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
        end
        in_valid_i = 1'b0;
    endtask

    // Output monitor: scoreboard pops on consumer handshakes, hold checks
    // while stalled, and (skid build) ready-drop after a skid capture.
    beat_t held;
    logic  hold_pending     = 1'b0;
    logic  expect_ready_low = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_pending     <= 1'b0;
            expect_ready_low <= 1'b0;
        end else begin
            if (hold_pending)
                check("hold_stable", {out_valid_o, taken_o, result_o, tag_o}, {1'b1, held});
`ifdef BRANCH_CMP_SKID_EN
            if (expect_ready_low)
                check("skid_in_ready_low", in_ready_o, 0);
            expect_ready_low <= out_valid_o && !out_ready_i && in_valid_i && in_ready_o;
`endif
            hold_pending <= out_valid_o && !out_ready_i;
            held         <= {taken_o, result_o, tag_o};
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got tag %0d expected no beat", tag_o);
                end else begin
                    check("result_beat", {taken_o, result_o, tag_o}, sb.pop_front());
                    popped++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[17];

    initial begin
        int t_first, t_last, pop_base;
        logic [15:0] rdy_pat;

        vecs[0]  = '{F3_BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'd0};
        vecs[1]  = '{F3_BLTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0};
        vecs[2]  = '{F3_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'd1};
        vecs[3]  = '{F3_SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'd0};
        vecs[4]  = '{F3_BEQ,  32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0};
        vecs[5]  = '{F3_BGE,  32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0};
        vecs[6]  = '{F3_BNE,  32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0};
        vecs[7]  = '{F3_BGEU, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'd0};
        vecs[8]  = '{F3_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1};
        vecs[9]  = '{F3_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0};
        vecs[10] = '{F3_BGE,  32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 32'd0};
        vecs[11] = '{F3_BLT,  32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, 32'd0};
        vecs[12] = '{F3_BLTU, 32'h0000_0003, 32'hFFFF_FFFD, 1'b1, 32'd0};
        vecs[13] = '{F3_BNE,  32'h0000_0001, 32'h0000_0002, 1'b1, 32'd0};
        vecs[14] = '{F3_BEQ,  32'h0000_0001, 32'h0000_0002, 1'b0, 32'd0};
        vecs[15] = '{F3_BGEU, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'd0};
        vecs[16] = '{F3_SLT,  32'h0000_0000, 32'h0000_0000, 1'b0, 32'd0};

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        a_i = '0; b_i = '0; funct3_i = '0; tag_i = '0;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_taken",     taken_o,     0);
        check("rst_result",    result_o,    0);
        check("rst_tag",       tag_o,       0);
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_in_ready", in_ready_o, 1);

        // Reset while FULL drops the beat immediately.
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        send(32'hFFFF_FFFF, 32'h0, F3_SLT, 5'd9, model(32'hFFFF_FFFF, 32'h0, F3_SLT, 5'd9));
        check("pre_rst_full", out_valid_o, 1);
        #2; rst_i = 1'b1;
        #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_result",    result_o,    0);
        check("midrst_tag",       tag_o,       0);
        sb.delete();
        @(posedge clk_i); #1; rst_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk_i);
        check("postrst_in_ready",  in_ready_o,  1);
        check("postrst_out_valid", out_valid_o, 0);

        // Table vectors: one-cycle latency and compare results.
        @(posedge clk_i); #1;
        for (int i = 0; i < 17; i++) begin
            beat_t e;
            e = '{taken: vecs[i].taken, result: vecs[i].result, tag: TAG_W'(i)};
            send(vecs[i].a, vecs[i].b, vecs[i].f3, TAG_W'(i), e);
            check($sformatf("vec%0d_valid_next", i), out_valid_o, 1);
            check($sformatf("vec%0d_taken_next", i), taken_o, vecs[i].taken);
        end
        repeat (2) @(posedge clk_i);
        #1;

        // Backpressure for 5 cycles, then 8 back-to-back beats.
        out_ready_i = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, F3_SLTU, 5'd21,
             model(32'h0000_0010, 32'h0000_0020, F3_SLTU, 5'd21));
        repeat (5) @(posedge clk_i);
        #1;
        check("bp_out_valid", out_valid_o, 1);
        check("bp_tag_held",  tag_o,       21);
`ifdef BRANCH_CMP_SKID_EN
        check("bp_in_ready", in_ready_o, 1);
`else
        check("bp_in_ready", in_ready_o, 0);
`endif
        out_ready_i = 1'b1;
        t_first = 0;
        t_last  = 0;
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] a, b;
            logic [2:0]   f;
            a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7));
            send(a, b, f, TAG_W'(k), model(a, b, f, TAG_W'(k)));
            if (k == 0) t_first = cyc;
            if (k == 7) t_last  = cyc;
        end
        check("b2b_cycles", t_last - t_first, 7);
        repeat (3) @(posedge clk_i);
        #1;
        check("b2b_drained", sb.size(), 0);

        // Streaming with random stalls: tags 0..15 in order, none lost or duplicated.
        pop_base = popped;
        rdy_pat  = 16'b1011_0011_1100_1101;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready_i = rdy_pat[i % 16];
                    @(posedge clk_i);
                    #1;
                end
                out_ready_i = 1'b1;
            end
            begin
                for (int t = 0; t < 16; t++) begin
                    logic [N-1:0] a, b;
                    logic [2:0]   f;
                    a = $urandom; b = $urandom; f = 3'($urandom_range(0, 7));
                    send(a, b, f, TAG_W'(t), model(a, b, f, TAG_W'(t)));
                end
            end
        join
        out_ready_i = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !out_valid_o) break;
        end
        check("stream_queue_empty", sb.size(), 0);
        check("stream_pop_count",   popped - pop_base, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
